// File: rtl/sequential_sobel_xy.sv
// Streaming 3x3 Sobel engine: builds the window from two internal line buffers and
// emits |Gy|, |Gx|, |Gx|+|Gy| or max(|Gx|,|Gy|) per accepted pixel, three cycles later.
module sequential_sobel_xy #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [PIX_W+2:0] out_data,
    output logic             out_neg
);
    localparam int LAT   = 3;
    localparam int COL_W = $clog2(LINE_W);
    localparam int G_W   = PIX_W + 3;

    function automatic logic [PIX_W+1:0] wsum_f(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [G_W-1:0] diff_f(input logic [PIX_W+1:0] p,
                                              input logic [PIX_W+1:0] n);
        return {1'b0, p} - {1'b0, n};
    endfunction

    function automatic logic [G_W-1:0] abs_f(input logic [G_W-1:0] d);
        return d[G_W-1] ? (~d + {{(G_W-1){1'b0}}, 1'b1}) : d;
    endfunction

    logic [COL_W-1:0] col_r, cur_col_s;
    logic [1:0]       row_r, cur_row_s;
    logic             line_start_s, incomplete_s;
    logic [PIX_W-1:0] lb0_r [LINE_W];
    logic [PIX_W-1:0] lb1_r [LINE_W];
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
    // Shift registers per window row: index 0 holds column c-1, index 1 holds c-2.
    logic [PIX_W-1:0] sr_top_r [2];
    logic [PIX_W-1:0] sr_mid_r [2];
    logic [PIX_W-1:0] sr_bot_r [2];
    logic [PIX_W-1:0] win_top_r [3];
    logic [PIX_W-1:0] win_mid_r [3];
    logic [PIX_W-1:0] win_bot_r [3];
    logic [1:0]       mode1_r, mode2_r;
    logic             mask1_r, mask2_r;
    logic [LAT-1:0]   vld_r;
    logic [PIX_W+1:0] top_sum_s, bot_sum_s, left_sum_s, right_sum_s;
    logic [G_W-1:0]   gx_r, gy_r, abs_gx_s, abs_gy_s, res_s;
    logic             neg_s;
    logic [G_W-1:0]   out_data_r;
    logic             out_neg_r;

    // Position of the pixel being accepted; a start of frame overrides the counters.
    always_comb begin
        if (in_sof) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = 2'd0;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
    end

    assign line_start_s = (cur_col_s == {COL_W{1'b0}});
    assign incomplete_s = (cur_row_s < 2'd2) || (cur_col_s < COL_W'(2));
    assign lb0_rd_s     = lb0_r[cur_col_s];
    assign lb1_rd_s     = lb1_r[cur_col_s];

    // Column/row counters; row saturates at 2 because only "at least two rows above" matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= 2'd0;
        end else if (in_valid) begin
            if (cur_col_s == COL_W'(LINE_W - 1)) begin
                col_r <= {COL_W{1'b0}};
                row_r <= (cur_row_s == 2'd2) ? 2'd2 : cur_row_s + 2'd1;
            end else begin
                col_r <= cur_col_s + COL_W'(1);
                row_r <= cur_row_s;
            end
        end
    end

    // Line buffers are never cleared; the row counter masks stale contents.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0_r[cur_col_s] <= in_pixel;
            lb1_r[cur_col_s] <= lb0_rd_s;
        end
    end

    // Stage 1: column shift registers and window/mode capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sr_top_r[i] <= {PIX_W{1'b0}};
                sr_mid_r[i] <= {PIX_W{1'b0}};
                sr_bot_r[i] <= {PIX_W{1'b0}};
            end
            for (int i = 0; i < 3; i++) begin
                win_top_r[i] <= {PIX_W{1'b0}};
                win_mid_r[i] <= {PIX_W{1'b0}};
                win_bot_r[i] <= {PIX_W{1'b0}};
            end
            mode1_r <= 2'b00;
            mask1_r <= 1'b1;
        end else if (in_valid) begin
            win_top_r[0] <= sr_top_r[1];
            win_top_r[1] <= sr_top_r[0];
            win_top_r[2] <= lb1_rd_s;
            win_mid_r[0] <= sr_mid_r[1];
            win_mid_r[1] <= sr_mid_r[0];
            win_mid_r[2] <= lb0_rd_s;
            win_bot_r[0] <= sr_bot_r[1];
            win_bot_r[1] <= sr_bot_r[0];
            win_bot_r[2] <= in_pixel;
            sr_top_r[0]  <= lb1_rd_s;
            sr_mid_r[0]  <= lb0_rd_s;
            sr_bot_r[0]  <= in_pixel;
            sr_top_r[1]  <= line_start_s ? {PIX_W{1'b0}} : sr_top_r[0];
            sr_mid_r[1]  <= line_start_s ? {PIX_W{1'b0}} : sr_mid_r[0];
            sr_bot_r[1]  <= line_start_s ? {PIX_W{1'b0}} : sr_bot_r[0];
            mode1_r      <= mode;
            mask1_r      <= incomplete_s;
        end
    end

    assign top_sum_s   = wsum_f(win_top_r[0], win_top_r[1], win_top_r[2]);
    assign bot_sum_s   = wsum_f(win_bot_r[0], win_bot_r[1], win_bot_r[2]);
    assign left_sum_s  = wsum_f(win_top_r[0], win_mid_r[0], win_bot_r[0]);
    assign right_sum_s = wsum_f(win_top_r[2], win_mid_r[2], win_bot_r[2]);

    // Valid pipeline: bubbles on in_valid travel through unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {LAT{1'b0}};
        end else begin
            vld_r <= {vld_r[LAT-2:0], in_valid};
        end
    end

    // Stage 2: signed gradients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_r    <= {G_W{1'b0}};
            gy_r    <= {G_W{1'b0}};
            mode2_r <= 2'b00;
            mask2_r <= 1'b1;
        end else if (vld_r[0]) begin
            gx_r    <= diff_f(right_sum_s, left_sum_s);
            gy_r    <= diff_f(top_sum_s, bot_sum_s);
            mode2_r <= mode1_r;
            mask2_r <= mask1_r;
        end
    end

    // Stage 3 combinational part: magnitudes and mode select.
    always_comb begin
        abs_gx_s = abs_f(gx_r);
        abs_gy_s = abs_f(gy_r);
        res_s    = {G_W{1'b0}};
        neg_s    = 1'b0;
        if (mask2_r) begin
            res_s = {G_W{1'b0}};
            neg_s = 1'b0;
        end else begin
            case (mode2_r)
                2'b00: begin
                    res_s = abs_gy_s;
                    neg_s = gy_r[G_W-1];
                end
                2'b01: begin
                    res_s = abs_gx_s;
                    neg_s = gx_r[G_W-1];
                end
                2'b10: res_s = abs_gx_s + abs_gy_s;
                2'b11: res_s = (abs_gx_s >= abs_gy_s) ? abs_gx_s : abs_gy_s;
                default: res_s = {G_W{1'b0}};
            endcase
        end
    end

    // Stage 3 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r <= {G_W{1'b0}};
            out_neg_r  <= 1'b0;
        end else if (vld_r[1]) begin
            out_data_r <= res_s;
            out_neg_r  <= neg_s;
        end
    end

    assign out_valid = vld_r[LAT-1];
    assign out_data  = out_data_r;
    assign out_neg   = out_neg_r;

endmodule

// File: tb/tb_sequential_sobel_xy.sv
// Scoreboard bench for sequential_sobel_xy with a 4-pixel line: stimulus pushes the
// hand-computed result and its due cycle; a negedge monitor pops and compares.
module tb_sequential_sobel_xy;
    localparam int PIX_W   = 8;
    localparam int LINE_W  = 4;
    localparam int K_CONST = 0;
    localparam int K_VERT  = 1;
    localparam int K_HORZ  = 2;
    localparam int K_SPOT  = 3;

    typedef struct {
        logic [PIX_W+2:0] data;
        logic             neg;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic [1:0]       mode;
    logic             out_valid;
    logic [PIX_W+2:0] out_data;
    logic             out_neg;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    sequential_sobel_xy #(.PIX_W(PIX_W), .LINE_W(LINE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .mode     (mode),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_neg  (out_neg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output must match the head of the scoreboard at its due cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: cycle %0d data %0d, expected no output", cyc, out_data);
                end else begin
                    e = sb_q.pop_front();
                    if (out_data !== e.data || out_neg !== e.neg || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL result: got data %0d neg %0d cycle %0d, expected data %0d neg %0d cycle %0d",
                                 out_data, out_neg, cyc, e.data, e.neg, e.cyc);
                    end
                end
            end
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                tests++;
                fails++;
                e = sb_q.pop_front();
                $display("FAIL missing_out: no output at cycle %0d, expected data %0d", e.cyc, e.data);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [PIX_W-1:0] img_px(input int kind, input int idx);
        logic [PIX_W-1:0] p;
        p = 8'd0;
        case (kind)
            K_CONST: p = 8'd100;
            K_VERT:  p = ((idx % LINE_W) >= 2) ? 8'd255 : 8'd0;
            K_HORZ:  p = (idx >= LINE_W) ? 8'd255 : 8'd0;
            K_SPOT:  p = (idx == 5) ? 8'd255 : 8'd0;
            default: p = 8'd0;
        endcase
        return p;
    endfunction

    task automatic send(input logic [PIX_W-1:0] pix, input logic sof, input logic [1:0] m,
                        input logic [PIX_W+2:0] ed, input logic en);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        mode     = m;
        e.data   = ed;
        e.neg    = en;
        e.cyc    = cyc + 3;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    // Pixels first..last of a 3x4 frame; only indices 10 and 11 (row 2, cols 2/3) can be nonzero.
    task automatic send_frame(input int kind, input logic [1:0] m, input logic [1:0] m_last,
                              input logic sof, input logic gap, input int first, input int last,
                              input logic [PIX_W+2:0] e10, input logic n10,
                              input logic [PIX_W+2:0] e11, input logic n11);
        for (int i = first; i <= last; i++) begin
            if (i == 10)
                send(img_px(kind, i), 1'b0, m, e10, n10);
            else if (i == 11)
                send(img_px(kind, i), 1'b0, m_last, e11, n11);
            else
                send(img_px(kind, i), sof && (i == first), m, 11'd0, 1'b0);
            if (gap) idle(2);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'd0;
        mode     = 2'b00;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_neg", int'(out_neg), 0);
        @(negedge clk) rst_n = 1'b1;

        send_frame(K_CONST, 2'b10, 2'b10, 1'b1, 1'b0, 0, 11, 11'd0, 1'b0, 11'd0, 1'b0);
        send_frame(K_VERT, 2'b01, 2'b01, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);
        send_frame(K_VERT, 2'b00, 2'b00, 1'b1, 1'b0, 0, 11, 11'd0, 1'b0, 11'd0, 1'b0);
        send_frame(K_HORZ, 2'b00, 2'b00, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b1, 11'd1020, 1'b1);
        send_frame(K_HORZ, 2'b10, 2'b10, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);
        send_frame(K_HORZ, 2'b11, 2'b11, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);
        // Mode change on the last pixel applies to that pixel only.
        send_frame(K_HORZ, 2'b00, 2'b10, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b1, 11'd1020, 1'b0);
        send_frame(K_SPOT, 2'b10, 2'b10, 1'b1, 1'b0, 0, 11, 11'd0, 1'b0, 11'd510, 1'b0);
        send_frame(K_SPOT, 2'b11, 2'b11, 1'b1, 1'b0, 0, 11, 11'd0, 1'b0, 11'd510, 1'b0);
        send_frame(K_VERT, 2'b01, 2'b01, 1'b1, 1'b1, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);
        // Partial frame interrupted mid-line by a new start of frame.
        send_frame(K_HORZ, 2'b01, 2'b01, 1'b1, 1'b0, 0, 9, 11'd0, 1'b0, 11'd0, 1'b0);
        send_frame(K_VERT, 2'b01, 2'b01, 1'b1, 1'b0, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);

        // Asynchronous reset mid-line with results still in flight.
        send_frame(K_VERT, 2'b01, 2'b01, 1'b1, 1'b0, 0, 5, 11'd0, 1'b0, 11'd0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("pre_reset_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_data", int'(out_data), 0);
        check("midreset_out_neg", int'(out_neg), 0);
        sb_q.delete();
        #10 rst_n = 1'b1;
        send_frame(K_VERT, 2'b01, 2'b01, 1'b0, 1'b0, 0, 11, 11'd1020, 1'b0, 11'd1020, 1'b0);

        idle(8);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequential_sobel_xy.md
Name: sequential_sobel_xy

Overview:
- Streaming 3x3 Sobel engine, a parametrised successor to the single-axis sequential Sobel stages.
- Accepts one raster-order pixel per valid cycle.
- Holds two line buffers internally and builds the 3x3 window itself.
- Outputs |Gx|, |Gy|, |Gx|+|Gy| or max(|Gx|,|Gy|) per pixel, selected at run time. Sits between the pixel source and the edge-threshold stage.

Parameters:
- PIX_W, 8, input pixel width in bits (unsigned).
- LINE_W, 640, pixels per image line; line-buffer depth; must be >= 3.
- LAT, 3, fixed input-to-output latency in cycles; documented only, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_pixel/in_sof/mode are valid this cycle.
- in_sof  input  1  start of frame; qualifies the pixel as row 0, col 0.
- in_pixel  input  PIX_W  unsigned pixel.
- mode  input  2  00=|Gy|, 01=|Gx|, 10=|Gx|+|Gy|, 11=max(|Gx|,|Gy|); sampled per pixel with in_valid.
- out_valid  output  1  out_data/out_neg valid.
- out_data  output  PIX_W+3  unsigned gradient result.
- out_neg  output  1  sign of the raw selected gradient (modes 00/01 only; 0 in 10/11).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_neg=0, column/row counters=0, pipeline valid bits=0. Line-buffer contents are not cleared; stale data is masked by the row counter.
- Counters:
  - col counts accepted pixels 0..LINE_W-1 and wraps to 0; the wrap increments row.
  - row saturates at 2.
  - in_sof&in_valid forces the accepted pixel to col=0,row=0, overriding any partial line. in_sof without in_valid is ignored.
- Window: on each accepted pixel P(r,c), form rows {r-2, r-1, r} × cols {c-2, c-1, c}, taken from line buffer 1, line buffer 0 and the live pixel, plus two column shift registers per row. Then write P into line buffer 0 and shift line buffer 0's old value into line buffer 1 at index c.
- Column shift registers clear at col=0 so no pixels leak across lines.
- Arithmetic, with weights [1 2 1] and newest column/row = right/bottom:
  - Gy = top-row weighted sum − bottom-row weighted sum.
  - Gx = right-column weighted sum − left-column weighted sum.
  - Weighted sums are PIX_W+2 bits unsigned. Differences are PIX_W+3 bits signed.
  - |G| is computed by two's complement, max 4·(2^PIX_W−1).
  - |Gx|+|Gy| is max 8·(2^PIX_W−1) and fits in PIX_W+3 bits with no saturation.
  - The max() compare is unsigned.
- Incomplete window: if the accepted pixel has row<2 or col<2, out_data=0 and out_neg=0, but out_valid still asserts. Rule: exactly one output per accepted input.
- Pipeline:
  - S1 captures window and mode.
  - S2 forms weighted sums and differences.
  - S3 forms abs, mode select and registers the outputs.
  - out_valid asserts exactly 3 cycles after the in_valid cycle of the corresponding pixel.
  - Gaps in in_valid propagate as bubbles (out_valid=0). Window/counter state advances only on in_valid.
  - No backpressure; consumer must always accept.
- Mode change between pixels takes effect on the next accepted pixel; in-flight results keep their own mode.
- Reset mid-frame: outputs drop immediately. The first post-reset pixel is treated as row 0, col 0 whether or not in_sof is present.
- Output ordering: result for window centre (r-1,c-1) is emitted in the slot of input (r,c). Line-edge centres (col 0, col LINE_W-1) and first/last rows never produce a nonzero value.

Test Plan:
- LINE_W=4, constant image of 100, mode=10, 12 pixels -> 12 out_valid pulses, each 3 cycles after its input; all out_data=0.
- Vertical edge, LINE_W=4: every row is 0,0,255,255; mode=01 -> row-2 col-2 output 1020, out_neg=0; row-2 col-3 output 1020. Same stream with mode=00 -> outputs 0.
- Horizontal edge: row 0 all 0, rows 1–2 all 255; mode=00 -> row-2 col≥2 outputs 1020, out_neg=1; mode=10 -> 1020; mode=11 -> 1020.
- Single 255 pixel at (1,1), rest 0; mode=10 -> result at input (2,2) = |Gx|+|Gy| = 0+0; at input (2,3) window has it left-middle: |Gx|=510, |Gy|=0 -> 510. Mode=11 same value.
- in_valid toggled 1,0,0,1,... over a frame -> out_valid pattern equals input pattern delayed 3 cycles; values match gap-free run. Mid-line in_sof -> counters restart and next two rows output 0.
- Assert rst_n=0 mid-line for 1 cycle (async, between edges) -> out_valid/out_data 0 immediately. Resume without in_sof -> first two rows output 0, then correct gradients.
